// File: rtl/aes_ctr_stream_xor.sv
// aes_ctr_stream_xor: XORs LANES plaintext bytes per beat with SBOX(key_byte ^ byte_index).
// Latency: 2 clk from input accept to valid_out, 1 beat/clk sustained throughput.
// Backpressure: ready_in = !(valid_out && !ready_out); a stalled output freezes both stages.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_in/ready_in   input beat handshake; new_message marks a message's first beat
//   key                 KEY_BYTES key bytes, captured on an accepted new_message beat
//   data_in/data_out    LANES byte lanes, lane j = bits [8j+7:8j]
//   valid_out/ready_out output beat handshake
//   err_out             one-cycle pulse: beat arrived with no open message (beat dropped)
//   wrap_out            one-cycle pulse: byte-index counter rolled over on that beat
// err_out/wrap_out are registered: they are high for the cycle after the accepting edge.
// Optional macro AES_STREAM_LAST_EN adds last_in/last_out; a last beat closes the message.
module aes_ctr_stream_xor #(
  parameter int LANES     = 1,
  parameter int KEY_BYTES = 1,
  parameter int CTR_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef AES_STREAM_LAST_EN
  input  logic                   last_in,
  output logic                   last_out,
`endif
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   new_message,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [8*LANES-1:0]     data_in,
  output logic [8*LANES-1:0]     data_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic                   err_out,
  output logic                   wrap_out
);

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_nx;
  logic [CTR_W-1:0]       ctr_q, ctr_nx, base;
  logic [CTR_W:0]         ctr_sum;
  logic [8*KEY_BYTES-1:0] key_q, key_src;
  logic                   stall, accept, discard, beat_ok, wrap_now, last_beat;
  logic [CTR_W-1:0]       n_idx [LANES];
  logic [31:0]            ksel  [LANES];
  logic [8*LANES-1:0]     mix, ks;
  logic                   s1_vld;
  logic [8*LANES-1:0]     s1_dat, s1_mix;

  assign stall    = valid_out && !ready_out;
  assign ready_in = !stall;
  assign accept   = valid_in && ready_in;
  // A continuation beat with no open message has nothing to belong to: drop and flag it.
  assign discard  = accept && (state_q == IDLE) && !new_message;
  assign beat_ok  = accept && !discard;

`ifdef AES_STREAM_LAST_EN
  assign last_beat = last_in;
`else
  assign last_beat = 1'b0;
`endif

  assign base     = new_message ? '0 : ctr_q;
  assign ctr_sum  = {1'b0, base} + (CTR_W+1)'(LANES);
  assign wrap_now = beat_ok && ctr_sum[CTR_W];
  // The first beat of a message must use the key presented with it, not the stale register.
  assign key_src  = new_message ? key : key_q;

  // Per-lane byte index (wraps at 2^CTR_W) and the key byte it selects.
  always_comb begin
    mix = '0;
    for (int j = 0; j < LANES; j++) begin
      n_idx[j]       = base + CTR_W'(j);
      ksel[j]        = 32'(n_idx[j]) % 32'(KEY_BYTES);
      mix[8*j +: 8]  = key_src[8*ksel[j] +: 8] ^ n_idx[j][7:0];
    end
  end

  always_comb begin
    ks = '0;
    for (int j = 0; j < LANES; j++) begin
      ks[8*j +: 8] = sbox(s1_mix[8*j +: 8]);
    end
  end

  // Message FSM and index counter.
  always_comb begin
    state_nx = state_q;
    ctr_nx   = ctr_q;
    if (beat_ok) begin
      state_nx = ACTIVE;
      ctr_nx   = ctr_sum[CTR_W-1:0];
      if (last_beat) begin
        state_nx = IDLE;
        ctr_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_nx;
      ctr_q   <= ctr_nx;
      if (beat_ok && new_message) key_q <= key;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_out  <= 1'b0;
      wrap_out <= 1'b0;
    end else begin
      err_out  <= discard;
      wrap_out <= wrap_now;
    end
  end

  // Two-stage datapath: stage 1 holds data + S-box address, stage 2 the ciphertext.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_dat    <= '0;
      s1_mix    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (!stall) begin
      s1_vld    <= beat_ok;
      s1_dat    <= data_in;
      s1_mix    <= mix;
      valid_out <= s1_vld;
      if (s1_vld) data_out <= s1_dat ^ ks;
    end
  end

`ifdef AES_STREAM_LAST_EN
  logic s1_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_last  <= 1'b0;
      last_out <= 1'b0;
    end else if (!stall) begin
      s1_last  <= last_in;
      last_out <= s1_vld && s1_last;
    end
  end
`endif

endmodule

// File: tb/tb_aes_ctr_stream_xor.sv
`timescale 1ns/1ps
module tb_aes_ctr_stream_xor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut1: LANES=1 KEY_BYTES=1 CTR_W=16 ; dut4: LANES=4 KEY_BYTES=3 CTR_W=8
  logic        v1_in, r1_in, nm1, v1_out, r1_out, err1, wrap1;
  logic [7:0]  key1, d1_in, d1_out;
  logic        v4_in, r4_in, nm4, v4_out, r4_out, err4, wrap4;
  logic [23:0] key4;
  logic [31:0] d4_in, d4_out;
`ifdef AES_STREAM_LAST_EN
  logic        lst1_in, lst1_out, lst4_in, lst4_out;
`endif

  aes_ctr_stream_xor #(.LANES(1), .KEY_BYTES(1), .CTR_W(16)) dut1 (
    .clk(clk), .reset(reset),
`ifdef AES_STREAM_LAST_EN
    .last_in(lst1_in), .last_out(lst1_out),
`endif
    .valid_in(v1_in), .ready_in(r1_in), .new_message(nm1), .key(key1),
    .data_in(d1_in), .data_out(d1_out), .valid_out(v1_out), .ready_out(r1_out),
    .err_out(err1), .wrap_out(wrap1)
  );

  aes_ctr_stream_xor #(.LANES(4), .KEY_BYTES(3), .CTR_W(8)) dut4 (
    .clk(clk), .reset(reset),
`ifdef AES_STREAM_LAST_EN
    .last_in(lst4_in), .last_out(lst4_out),
`endif
    .valid_in(v4_in), .ready_in(r4_in), .new_message(nm4), .key(key4),
    .data_in(d4_in), .data_out(d4_out), .valid_out(v4_out), .ready_out(r4_out),
    .err_out(err4), .wrap_out(wrap4)
  );

  typedef struct { logic nm; logic [127:0] key; logic [127:0] dat; logic last; } beat_t;
  typedef struct { logic [127:0] dat; logic last; int acc; } exp_t;

  int checks = 0;
  int errors = 0;

  beat_t        stim[$];
  bit           rdy_pat[$];
  exp_t         sb[$];
  logic [127:0] out_dat[$];
  logic         out_last[$];
  int           lat[$];
  int           ocyc[$];
  int           err_cnt, wrap_cnt, stall_cnt, acc_cnt, wrap_idx;
  logic         pend_err, pend_wrap;
  logic         m_active;
  longint unsigned m_c;
  logic [127:0] m_key;

  // Reference S-box from its definition: GF(2^8) inverse then the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a = a_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0]  inv = 8'h01;
    logic [7:0]  sq  = x;
    logic [15:0] t;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, sq);   // x^254 = x^(2+4+...+128)
      sq = gmul(sq, sq);
    end
    t = {inv, inv};
    return inv ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
  endfunction

  function automatic logic [127:0] exp_beat(input int lanes, input int kbytes, input int cw,
                                            input logic [127:0] keyv, input logic [127:0] din,
                                            input longint unsigned base);
    logic [127:0] r = '0;
    for (int j = 0; j < lanes; j++) begin
      longint unsigned n = (base + longint'(j)) % (64'd1 << cw);
      int ksi = int'(n % longint'(kbytes));
      r[8*j +: 8] = din[8*j +: 8] ^ sbox_ref(keyv[8*ksi +: 8] ^ 8'(n));
    end
    return r;
  endfunction

  // Reference message model: updates state and pushes the expected output.
  task automatic model_accept(input int sel, input beat_t b);
    int lanes  = sel ? 4 : 1;
    int kbytes = sel ? 3 : 1;
    int cw     = sel ? 8 : 16;
    longint unsigned modv = 64'd1 << cw;
    longint unsigned base, sum;
    exp_t e;
    if (!m_active && !b.nm) begin
      pend_err = 1'b1;
      return;
    end
    base = b.nm ? 64'd0 : m_c;
    if (b.nm) m_key = b.key;
    sum = base + longint'(lanes);
    pend_wrap = (sum >= modv);
    if (pend_wrap) wrap_idx = acc_cnt;
    m_c = sum % modv;
    m_active = 1'b1;
    e.dat  = exp_beat(lanes, kbytes, cw, m_key, b.dat, base);
    e.last = b.last;
    e.acc  = cyc;
    sb.push_back(e);
    acc_cnt++;
    if (b.last) begin
      m_active = 1'b0;
      m_c = 0;
    end
  endtask

  task automatic clear_model();
    stim.delete(); rdy_pat.delete(); sb.delete();
    out_dat.delete(); out_last.delete(); lat.delete(); ocyc.delete();
    err_cnt = 0; wrap_cnt = 0; stall_cnt = 0; acc_cnt = 0; wrap_idx = -1;
    pend_err = 1'b0; pend_wrap = 1'b0;
    m_active = 1'b0; m_c = 0; m_key = '0;
  endtask

  task automatic idle_inputs();
    v1_in = 0; nm1 = 0; key1 = '0; d1_in = '0; r1_out = 1;
    v4_in = 0; nm4 = 0; key4 = '0; d4_in = '0; r4_out = 1;
`ifdef AES_STREAM_LAST_EN
    lst1_in = 0; lst4_in = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  function automatic beat_t mk(input logic nm, input logic [127:0] k, input logic [127:0] d,
                               input logic last);
    beat_t b;
    b.nm = nm; b.key = k; b.dat = d; b.last = last;
    return b;
  endfunction

  // Cycle engine: drives stim/rdy_pat into the selected DUT and scores its outputs.
  task automatic run(input int sel, input int ncyc, input bit drain);
    int t = 0;
    bit done = 0;
    logic vo, eo, wo, lo, ro, ri, vi;
    logic [127:0] dout;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      lo = 1'b0;
      if (sel == 0) begin vo = v1_out; dout = 128'(d1_out); eo = err1; wo = wrap1; end
      else          begin vo = v4_out; dout = 128'(d4_out); eo = err4; wo = wrap4; end
`ifdef AES_STREAM_LAST_EN
      lo = (sel == 0) ? lst1_out : lst4_out;
`endif
      checks++;
      if (eo !== pend_err) begin
        errors++; $display("FAIL err_out: got %b expected %b (cycle %0d)", eo, pend_err, cyc);
      end
      checks++;
      if (wo !== pend_wrap) begin
        errors++; $display("FAIL wrap_out: got %b expected %b (cycle %0d)", wo, pend_wrap, cyc);
      end
      if (eo === 1'b1) err_cnt++;
      if (wo === 1'b1) wrap_cnt++;
      ro = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      if (sel == 0) r1_out = ro; else r4_out = ro;
      if (vo !== 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL spurious_output: got data %h expected no beat", dout);
        end else begin
          if (dout !== sb[0].dat || lo !== sb[0].last) begin
            errors++;
            $display("FAIL data_out: got %h/%b expected %h/%b", dout, lo, sb[0].dat, sb[0].last);
          end
          if (ro) begin
            e = sb.pop_front();
            out_dat.push_back(dout); out_last.push_back(lo);
            lat.push_back(cyc - e.acc); ocyc.push_back(cyc);
          end
        end
      end
      vi = (stim.size() > 0);
      if (sel == 0) begin
        v1_in = vi; nm1 = vi ? stim[0].nm : 1'b0;
        key1 = vi ? stim[0].key[7:0] : 8'h0; d1_in = vi ? stim[0].dat[7:0] : 8'h0;
      end else begin
        v4_in = vi; nm4 = vi ? stim[0].nm : 1'b0;
        key4 = vi ? stim[0].key[23:0] : 24'h0; d4_in = vi ? stim[0].dat[31:0] : 32'h0;
      end
`ifdef AES_STREAM_LAST_EN
      if (sel == 0) lst1_in = vi ? stim[0].last : 1'b0;
      else          lst4_in = vi ? stim[0].last : 1'b0;
`endif
      #1;
      ri = (sel == 0) ? r1_in : r4_in;
      if (vo === 1'b1 && !ro) begin
        stall_cnt++;
        checks++;
        if (ri !== 1'b0) begin
          errors++; $display("FAIL ready_in_stall: got %b expected 0", ri);
        end
      end
      pend_err = 1'b0;
      pend_wrap = 1'b0;
      if (vi && ri === 1'b1) model_accept(sel, stim.pop_front());
      t++;
      if (drain && stim.size() == 0 && sb.size() == 0 && !pend_err && !pend_wrap) done = 1;
      else if (t >= ncyc) begin
        done = 1;
        if (drain) begin
          checks++; errors++;
          $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size() + stim.size());
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    v1_in = 1; nm1 = 1; key1 = 8'h11; v4_in = 1; nm4 = 1;
    repeat (3) @(negedge clk);
    checks += 10;
    if (v1_out !== 1'b0) begin errors++; $display("FAIL rst_v1: got %b expected 0", v1_out); end
    if (d1_out !== 8'h0) begin errors++; $display("FAIL rst_d1: got %h expected 00", d1_out); end
    if (err1 !== 1'b0)   begin errors++; $display("FAIL rst_err1: got %b expected 0", err1); end
    if (wrap1 !== 1'b0)  begin errors++; $display("FAIL rst_wrap1: got %b expected 0", wrap1); end
    if (r1_in !== 1'b1)  begin errors++; $display("FAIL rst_rdy1: got %b expected 1", r1_in); end
    if (v4_out !== 1'b0) begin errors++; $display("FAIL rst_v4: got %b expected 0", v4_out); end
    if (d4_out !== 32'h0) begin errors++; $display("FAIL rst_d4: got %h expected 0", d4_out); end
    if (err4 !== 1'b0)   begin errors++; $display("FAIL rst_err4: got %b expected 0", err4); end
    if (wrap4 !== 1'b0)  begin errors++; $display("FAIL rst_wrap4: got %b expected 0", wrap4); end
    if (r4_in !== 1'b1)  begin errors++; $display("FAIL rst_rdy4: got %b expected 1", r4_in); end
    idle_inputs();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_basic();
    logic [7:0] want [3] = '{8'h82, 8'hCA, 8'h82};
    do_reset();
    stim.push_back(mk(1, 128'h11, 128'h00, 0));
    stim.push_back(mk(0, 128'h00, 128'h00, 0));
    stim.push_back(mk(0, 128'h00, 128'hFF, 0));
    run(0, 40, 1);
    checks++;
    if (out_dat.size() != 3) begin
      errors++; $display("FAIL basic_count: got %0d expected 3", out_dat.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (out_dat[i] !== 128'(want[i])) begin
          errors++; $display("FAIL basic_data%0d: got %h expected %h", i, out_dat[i], want[i]);
        end
        if (lat[i] != 2) begin
          errors++; $display("FAIL basic_latency%0d: got %0d expected 2", i, lat[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    stim.push_back(mk(1, 128'h11, 128'h00, 0));
    stim.push_back(mk(0, 128'h00, 128'h00, 0));
    stim.push_back(mk(0, 128'h00, 128'hFF, 0));
    rdy_pat = '{1, 1, 0, 0, 0, 0, 0};
    run(0, 40, 1);
    checks += 2;
    if (stall_cnt != 5) begin
      errors++; $display("FAIL stall_cycles: got %0d expected 5", stall_cnt);
    end
    if (ocyc.size() != 3) begin
      errors++; $display("FAIL stall_count: got %0d expected 3", ocyc.size());
    end else begin
      checks++;
      if (ocyc[2] - ocyc[1] != 1 || ocyc[1] - ocyc[0] != 1) begin
        errors++;
        $display("FAIL stall_b2b: got gaps %0d,%0d expected 1,1", ocyc[1]-ocyc[0], ocyc[2]-ocyc[1]);
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    stim.push_back(mk(0, 128'h00, 128'h55, 0));
    stim.push_back(mk(1, 128'h11, 128'h00, 0));
    run(0, 40, 1);
    checks += 2;
    if (err_cnt != 1) begin errors++; $display("FAIL err_pulses: got %0d expected 1", err_cnt); end
    if (out_dat.size() != 1 || out_dat[0] !== 128'h82) begin
      errors++;
      $display("FAIL err_recover: got %0d beats first %h expected 1 beat 82", out_dat.size(),
               (out_dat.size() > 0) ? out_dat[0] : 128'h0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65; i++) stim.push_back(mk(i == 0, 128'h0, 128'h0, 0));
    run(1, 300, 1);
    checks += 3;
    if (wrap_cnt != 1 || wrap_idx != 63) begin
      errors++; $display("FAIL wrap_beat: got %0d pulses at beat %0d expected 1 at 63", wrap_cnt, wrap_idx);
    end
    if (out_dat.size() != 65) begin
      errors++; $display("FAIL wrap_count: got %0d expected 65", out_dat.size());
    end else if (out_dat[64] !== 128'h7B777C63 || out_dat[0] !== 128'h7B777C63) begin
      errors++; $display("FAIL wrap_lanes: got %h/%h expected 7b777c63", out_dat[0], out_dat[64]);
    end
  endtask

  task automatic test_multikey();
    do_reset();
    for (int i = 0; i < 80; i++)
      stim.push_back(mk(i == 0 || i == 75, 128'($urandom()), 128'($urandom()), 0));
    for (int i = 0; i < 200; i++) rdy_pat.push_back(bit'($urandom_range(0, 1)));
    run(1, 600, 1);
    checks++;
    if (out_dat.size() != 80) begin
      errors++; $display("FAIL multikey_count: got %0d expected 80", out_dat.size());
    end
  endtask

  task automatic test_reset_flight();
    do_reset();
    stim.push_back(mk(1, 128'h11, 128'h00, 0));
    stim.push_back(mk(0, 128'h00, 128'h00, 0));
    stim.push_back(mk(0, 128'h00, 128'hFF, 0));
    run(0, 2, 0);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (v1_out !== 1'b0) begin errors++; $display("FAIL flight_rst: got valid %b expected 0", v1_out); end
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (v1_out !== 1'b0) begin errors++; $display("FAIL flight_stale: got valid %b expected 0", v1_out); end
    end
    stim.push_back(mk(1, 128'h11, 128'h00, 0));
    run(0, 40, 1);
    checks++;
    if (out_dat.size() != 1 || out_dat[0] !== 128'h82) begin
      errors++; $display("FAIL flight_fresh: got %0d beats expected 1 beat 82", out_dat.size());
    end
  endtask

`ifdef AES_STREAM_LAST_EN
  task automatic test_last();
    do_reset();
    stim.push_back(mk(1, 128'h11, 128'h00, 1));
    stim.push_back(mk(0, 128'h00, 128'h33, 0));
    run(0, 40, 1);
    checks += 2;
    if (out_dat.size() != 1 || out_dat[0] !== 128'h82 || out_last[0] !== 1'b1) begin
      errors++; $display("FAIL last_beat: got %0d beats expected one 82 with last_out=1", out_dat.size());
    end
    if (err_cnt != 1) begin errors++; $display("FAIL last_err: got %0d expected 1", err_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    clear_model();
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_wrap();
    test_multikey();
    test_reset_flight();
`ifdef AES_STREAM_LAST_EN
    test_last();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
